// File: rtl/wino_pkg.sv
// Shared types and constants for the Winograd F(2x2,3x3) filter transform.
// Element widths, output modes and tile geometry.
package wino_pkg;
  localparam int WINO_W = 8;

  typedef logic signed [WINO_W-1:0] elem_t;
  typedef logic signed [WINO_W+3:0] wide_t;

  localparam int WINO_SCALED = 0;
  localparam int WINO_FLOOR  = 1;
  localparam int WINO_ROUND  = 2;

  localparam int TILE_IN  = 3;
  localparam int TILE_OUT = 4;
endpackage

// File: rtl/winograd_1d_transform.sv
// One-dimensional F(2,3) filter transform with the 1/2 factors scaled out.
// Maps (a,b,c) to (2a, a+b+c, a-b+c, 2c); two guard bits make it exact.
module winograd_1d_transform
  import wino_pkg::*;
#(
  parameter int IW = 8
) (
  input  logic signed [IW-1:0] a_i,
  input  logic signed [IW-1:0] b_i,
  input  logic signed [IW-1:0] c_i,
  output logic signed [IW+1:0] y0_o,
  output logic signed [IW+1:0] y1_o,
  output logic signed [IW+1:0] y2_o,
  output logic signed [IW+1:0] y3_o
);

  logic signed [IW+1:0] a;
  logic signed [IW+1:0] b;
  logic signed [IW+1:0] c;

  assign a = {{2{a_i[IW-1]}}, a_i};
  assign b = {{2{b_i[IW-1]}}, b_i};
  assign c = {{2{c_i[IW-1]}}, c_i};

  assign y0_o = a <<< 1;
  assign y1_o = a + b + c;
  assign y2_o = a - b + c;
  assign y3_o = c <<< 1;

endmodule

// File: rtl/winograd_filter_transform_pipe.sv
// Two-stage streaming Winograd F(2x2,3x3) filter transform with handshake.
// Stage1 holds the column transform, stage2 the converted 4x4 tile.
module winograd_filter_transform_pipe
  import wino_pkg::*;
#(
  parameter int W     = 8,
  parameter int OW    = 12,
  parameter int MODE  = 0,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [9*W-1:0]     in_filter,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [16*OW-1:0]   out_filter,
  output logic [TAG_W-1:0]   out_tag,
  output logic [CNT_W-1:0]   filter_count
);

  localparam int TW = W + 2;
  localparam int SW = W + 4;
  localparam int CW = W + 5;

  logic signed [TW-1:0] t_d [12];
  logic signed [TW-1:0] s1_t_q [12];
  logic signed [SW-1:0] s_w [16];
  logic [16*OW-1:0]     out_d;
  logic [16*OW-1:0]     out_q;
  logic [TAG_W-1:0]     s1_tag_q;
  logic [TAG_W-1:0]     s2_tag_q;
  logic                 s1_valid_q;
  logic                 s1_valid_d;
  logic                 s2_valid_q;
  logic                 s2_valid_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic                 s1_load;
  logic                 s2_load;

  // Column transform: each filter column becomes four T entries.
  for (genvar c = 0; c < TILE_IN; c++) begin : g_col
    winograd_1d_transform #(.IW(W)) u_col (
      .a_i  (in_filter[(0*3+c)*W +: W]),
      .b_i  (in_filter[(1*3+c)*W +: W]),
      .c_i  (in_filter[(2*3+c)*W +: W]),
      .y0_o (t_d[0*3+c]),
      .y1_o (t_d[1*3+c]),
      .y2_o (t_d[2*3+c]),
      .y3_o (t_d[3*3+c])
    );
  end

  // Row transform: each T row becomes one row of S = 4U.
  for (genvar r = 0; r < TILE_OUT; r++) begin : g_row
    winograd_1d_transform #(.IW(TW)) u_row (
      .a_i  (s1_t_q[r*3+0]),
      .b_i  (s1_t_q[r*3+1]),
      .c_i  (s1_t_q[r*3+2]),
      .y0_o (s_w[r*4+0]),
      .y1_o (s_w[r*4+1]),
      .y2_o (s_w[r*4+2]),
      .y3_o (s_w[r*4+3])
    );
  end

  // Scale by the selected mode, then clamp into the OW-bit range.
  function automatic logic [OW-1:0] conv(input logic signed [SW-1:0] s);
    logic signed [CW-1:0] e;
    logic signed [63:0]   v;
    logic signed [63:0]   hi;
    logic signed [63:0]   lo;
    e = {s[SW-1], s};
    if (MODE == WINO_FLOOR) begin
      e = e >>> 2;
    end else if (MODE == WINO_ROUND) begin
      e = e + CW'(2);
      e = e >>> 2;
    end
    v  = {{(64-CW){e[CW-1]}}, e};
    hi = (64'sd1 <<< (OW-1)) - 64'sd1;
    lo = -(64'sd1 <<< (OW-1));
    if (v > hi) v = hi;
    else if (v < lo) v = lo;
    return v[OW-1:0];
  endfunction

  // Output conversion feeding the stage2 register.
  always_comb begin
    out_d = '0;
    for (int k = 0; k < 16; k++) begin
      out_d[k*OW +: OW] = conv(s_w[k]);
    end
  end

  assign s2_load = !s2_valid_q || out_ready;
  assign s1_load = !s1_valid_q || s2_load;

  // Valid and counter next-state.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    cnt_d      = cnt_q;
    if (s1_load) s1_valid_d = in_valid;
    if (s2_load) s2_valid_d = s1_valid_q;
    if (s2_valid_q && out_ready) cnt_d = cnt_q + CNT_W'(1);
  end

  // Control state: stage valids and completed-filter counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  // Datapath registers only move on a real transfer into the stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 12; k++) s1_t_q[k] <= '0;
      s1_tag_q <= '0;
      out_q    <= '0;
      s2_tag_q <= '0;
    end else begin
      if (s1_load && in_valid) begin
        for (int k = 0; k < 12; k++) s1_t_q[k] <= t_d[k];
        s1_tag_q <= in_tag;
      end
      if (s2_load && s1_valid_q) begin
        out_q    <= out_d;
        s2_tag_q <= s1_tag_q;
      end
    end
  end

  assign in_ready     = !rst && s1_load;
  assign out_valid    = s2_valid_q && !rst;
  assign out_filter   = out_q;
  assign out_tag      = s2_tag_q;
  assign filter_count = cnt_q;

endmodule

// File: tb/tb_winograd_filter_transform_pipe.sv
// Self-checking bench for winograd_filter_transform_pipe.
// Four instances share one input stream: SCALED/12, FLOOR/12, ROUND/12, SCALED/8.
module tb_winograd_filter_transform_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [71:0] in_filter;
  logic [3:0]  in_tag;
  logic        out_ready;

  logic        rdy [4];
  logic        ov  [4];
  logic [3:0]  ot  [4];
  logic [15:0] cnt [4];
  logic [191:0] of0;
  logic [191:0] of1;
  logic [191:0] of2;
  logic [127:0] of3;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int pops  = 0;

  logic [71:0] q_f [$];
  logic [3:0]  q_t [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  winograd_filter_transform_pipe #(.W(8), .OW(12), .MODE(0)) d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_filter(in_filter), .in_tag(in_tag), .out_valid(ov[0]),
    .out_ready(out_ready), .out_filter(of0), .out_tag(ot[0]),
    .filter_count(cnt[0]));
  winograd_filter_transform_pipe #(.W(8), .OW(12), .MODE(1)) d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_filter(in_filter), .in_tag(in_tag), .out_valid(ov[1]),
    .out_ready(out_ready), .out_filter(of1), .out_tag(ot[1]),
    .filter_count(cnt[1]));
  winograd_filter_transform_pipe #(.W(8), .OW(12), .MODE(2)) d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_filter(in_filter), .in_tag(in_tag), .out_valid(ov[2]),
    .out_ready(out_ready), .out_filter(of2), .out_tag(ot[2]),
    .filter_count(cnt[2]));
  winograd_filter_transform_pipe #(.W(8), .OW(8), .MODE(0)) d3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[3]),
    .in_filter(in_filter), .in_tag(in_tag), .out_valid(ov[3]),
    .out_ready(out_ready), .out_filter(of3), .out_tag(ot[3]),
    .filter_count(cnt[3]));

  task automatic check(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Golden model: S = (2G) g (2G)^T by plain matrix products.
  function automatic logic [255:0] model(input logic [71:0] f,
                                         input int mode, input int ow);
    int g [3][3];
    int gm [4][3];
    int s, v, hi, lo;
    logic [255:0] r;
    gm = '{'{2, 0, 0}, '{1, 1, 1}, '{1, -1, 1}, '{0, 0, 2}};
    r = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        g[i][j] = int'($signed(f[(i*3+j)*8 +: 8]));
    hi = (1 << (ow-1)) - 1;
    lo = -(1 << (ow-1));
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int k = 0; k < 3; k++)
          for (int l = 0; l < 3; l++)
            s += gm[i][k] * g[k][l] * gm[j][l];
        if (mode == 0) v = s;
        else if (mode == 1) v = s >>> 2;
        else v = (s + 2) >>> 2;
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        for (int b = 0; b < ow; b++) r[(i*4+j)*ow+b] = v[b];
      end
    return r;
  endfunction

  function automatic int el(input logic [255:0] vec, input int k,
                            input int ow);
    logic [255:0] sh;
    int r;
    sh = vec >> (k*ow);
    r = 0;
    for (int b = 0; b < ow; b++) r[b] = sh[b];
    if (sh[ow-1]) r = r - (1 << ow);
    return r;
  endfunction

  function automatic logic [71:0] fill(input int val);
    logic [7:0] e;
    e = val[7:0];
    return {9{e}};
  endfunction

  // Scoreboard: pairs every output transfer with the oldest accepted input.
  always @(negedge clk) begin
    if (rst) begin
      q_f.delete();
      q_t.delete();
    end else begin
      if (ov[0] && out_ready) begin
        if (q_f.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          logic [71:0] f;
          logic [3:0]  t;
          f = q_f.pop_front();
          t = q_t.pop_front();
          check("sb_scaled", of0, model(f, 0, 12));
          check("sb_floor",  of1, model(f, 1, 12));
          check("sb_round",  of2, model(f, 2, 12));
          check("sb_sat8",   of3, model(f, 0, 8));
          check("sb_tag",    ot[0], t);
        end
        pops++;
      end
      if (in_valid && rdy[0]) begin
        q_f.push_back(in_filter);
        q_t.push_back(in_tag);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single filter with out_ready=1: accepted now, visible two cycles later.
  task automatic run_one(input string nm, input logic [71:0] f,
                         input logic [3:0] t);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_filter = f;
    in_tag    = t;
    @(negedge clk);
    check({nm, "_acc"}, rdy[0], 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check({nm, "_lat1"}, ov[0], 0);
    @(negedge clk);
    check({nm, "_lat2"}, ov[0], 1);
  endtask

  task automatic push_one(input logic [71:0] f, input logic [3:0] t);
    bit acc;
    in_valid  = 1'b1;
    in_filter = f;
    in_tag    = t;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      acc = rdy[0];
      tick();
      if (acc) break;
      if (n == 49) check("push_timeout", 0, 1);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    logic [71:0]  sf [3];
    logic [191:0] snap;
    logic [95:0]  rnd;
    int idx, base, sent, guard, nacc, npop, fa, fp, lp;
    bit acc;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_filter = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_out_valid", ov[0], 0);
    check("rst_in_ready",  rdy[0], 0);
    check("rst_count",     cnt[0], 0);
    check("rst_filter",    of0, 0);
    check("rst_tag",       ot[0], 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", rdy[0], 1);
    tick();

    run_one("ones", fill(1), 4'd3);
    check("ones_s0",  el(of0, 0, 12), 4);
    check("ones_s1",  el(of0, 1, 12), 6);
    check("ones_s5",  el(of0, 5, 12), 9);
    check("ones_s6",  el(of0, 6, 12), 3);
    check("ones_s15", el(of0, 15, 12), 4);
    check("ones_f0",  el(of1, 0, 12), 1);
    check("ones_f1",  el(of1, 1, 12), 1);
    check("ones_f5",  el(of1, 5, 12), 2);
    check("ones_f6",  el(of1, 6, 12), 0);
    check("ones_f15", el(of1, 15, 12), 1);
    check("ones_r0",  el(of2, 0, 12), 1);
    check("ones_r1",  el(of2, 1, 12), 2);
    check("ones_r5",  el(of2, 5, 12), 2);
    check("ones_r6",  el(of2, 6, 12), 1);
    check("ones_r15", el(of2, 15, 12), 1);
    check("ones_tag", ot[0], 3);
    tick();

    run_one("neg", fill(-128), 4'd5);
    check("neg_s5",    el(of0, 5, 12), -1152);
    check("neg_s0",    el(of0, 0, 12), -512);
    check("neg_sat5",  el(of3, 5, 8), -128);
    check("neg_sat0",  el(of3, 0, 8), -128);
    tick();
    check("count_two", cnt[0], 2);

    sf[0] = fill(5);
    sf[1] = fill(-7);
    sf[2] = fill(100);
    out_ready = 1'b0;
    idx       = 0;
    in_valid  = 1'b1;
    in_filter = sf[0];
    in_tag    = 4'd1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      acc = in_valid && rdy[0];
      tick();
      if (acc) begin
        idx++;
        if (idx < 3) begin
          in_filter = sf[idx];
          in_tag    = 4'(idx + 1);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check("stall_accepts", idx, 2);
    @(negedge clk);
    check("stall_in_ready", rdy[0], 0);
    check("stall_valid", ov[0], 1);
    snap = of0;
    repeat (3) tick();
    @(negedge clk);
    check("stall_stable", of0, snap);
    check("stall_tag", ot[0], 1);
    tick();
    base = pops;
    out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      acc = in_valid && rdy[0];
      tick();
      if (acc) begin
        idx++;
        in_valid = 1'b0;
      end
      if (idx == 3 && pops - base == 3) break;
    end
    check("stall_drain", pops - base, 3);
    check("stall_sb_empty", q_f.size(), 0);

    nacc = 0;
    npop = 0;
    fa = -1;
    fp = -1;
    lp = -1;
    out_ready = 1'b1;
    for (int n = 0; n < 14; n++) begin
      in_valid  = (n < 8);
      in_filter = fill(n * 13 - 50);
      in_tag    = 4'(n);
      @(negedge clk);
      if (in_valid && rdy[0]) begin
        nacc++;
        if (fa < 0) fa = cyc;
      end
      if (ov[0]) begin
        npop++;
        if (fp < 0) fp = cyc;
        lp = cyc;
      end
      tick();
    end
    in_valid = 1'b0;
    check("stream_acc", nacc, 8);
    check("stream_pop", npop, 8);
    check("stream_first", fp - fa, 2);
    check("stream_back2back", lp - fp, 7);

    out_ready = 1'b0;
    push_one(fill(3), 4'd11);
    push_one(fill(-3), 4'd12);
    out_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_no_xfer", ov[0], 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", ov[0], 0);
    check("mid_rst_count", cnt[0], 0);
    tick();
    run_one("after_rst", fill(7), 4'd9);
    check("after_rst_tag", ot[0], 9);
    check("after_rst_s5", el(of0, 5, 12), 63);
    tick();

    rst = 1'b1;
    tick();
    rst = 1'b0;
    base  = pops;
    sent  = 0;
    guard = 0;
    while (pops - base < 10000 && guard < 60000) begin
      in_valid = (sent < 10000) && ($urandom_range(0, 4) != 0);
      rnd = {$urandom, $urandom, $urandom};
      in_filter = rnd[71:0];
      in_tag    = rnd[75:72];
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && rdy[0];
      tick();
      if (acc) sent++;
      guard++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("rand_timeout", guard < 60000, 1);
    check("rand_pops", pops - base, 10000);
    @(negedge clk);
    check("rand_count", cnt[0], 10000);
    check("rand_sb_empty", q_f.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
